// File: rtl/su_adder_param_irrel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | su_adder_param_irrel: runtime-configurable SU psum adder; packs lane     |
// | sums of PE psum groups into one BRAM word per RF entry.                  |
// | Optional macro: SU_ADDER_SAT_EN (saturating lanes instead of wrap).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module su_adder_param_irrel #(
  parameter int ROW                   = 16,
  parameter int COL                   = 16,
  parameter int DATA_BITWIDTH         = 16,
  parameter int GBF_DATA_BITWIDTH     = 512,
  parameter int PSUM_RF_ADDR_BITWIDTH = 2,
  parameter int NUM_BITWIDTH          = 9,
  parameter int BRAM_ADDR_BITWIDTH    = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DATA_BITWIDTH*ROW*COL-1:0]     psum_out,
  input  logic                                 pe_psum_finish,
  input  logic                                 conv_finish,
  input  logic [NUM_BITWIDTH-1:0]              irrel_num,
  input  logic [NUM_BITWIDTH-1:0]              rel_num,
  input  logic [PSUM_RF_ADDR_BITWIDTH:0]       rf_num,
  output logic [PSUM_RF_ADDR_BITWIDTH-1:0]     psum_rf_addr,
  output logic [GBF_DATA_BITWIDTH-1:0]         out_data,
  output logic                                 psum_write_en,
  output logic [BRAM_ADDR_BITWIDTH-1:0]        psum_BRAM_addr,
  output logic                                 su_add_finish,
  output logic                                 cfg_err
);

  localparam int LANES  = GBF_DATA_BITWIDTH / DATA_BITWIDTH;
  localparam int NUM_PE = ROW * COL;
  localparam int SUM_W  = DATA_BITWIDTH + $clog2(NUM_PE) + 1;
  localparam int PROD_W = 2 * NUM_BITWIDTH;
  localparam int RFN_W  = PSUM_RF_ADDR_BITWIDTH + 1;

  localparam logic signed [SUM_W-1:0] C_SAT_MAX =
    {{(SUM_W-DATA_BITWIDTH+1){1'b0}}, {(DATA_BITWIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] C_SAT_MIN = ~C_SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e                           state_q, state_d;
  logic [NUM_BITWIDTH-1:0]          irrel_q, irrel_d;
  logic [NUM_BITWIDTH-1:0]          rel_q, rel_d;
  logic [RFN_W-1:0]                 rf_num_q, rf_num_d;
  logic [PSUM_RF_ADDR_BITWIDTH-1:0] rf_addr_q, rf_addr_d;
  logic                             rd_q, rd_d;
  logic [GBF_DATA_BITWIDTH-1:0]     out_data_q, out_data_d;
  logic                             wr_en_q, wr_en_d;
  logic [BRAM_ADDR_BITWIDTH-1:0]    bram_addr_q, bram_addr_d;
  logic                             cfg_err_q, cfg_err_d;
  logic                             conv_pend_q, conv_pend_d;

  logic [PROD_W-1:0]                cfg_prod;
  logic                             cfg_legal;
  logic [GBF_DATA_BITWIDTH-1:0]     lanes_packed;

  assign cfg_prod  = PROD_W'(irrel_num) * PROD_W'(rel_num);
  assign cfg_legal = (irrel_num != '0) && (rel_num != '0) &&
                     (rel_num <= NUM_BITWIDTH'(LANES)) &&
                     (cfg_prod <= PROD_W'(NUM_PE)) && (rf_num != '0);

  // Lane g owns PE indices [g*irrel, (g+1)*irrel); lanes at or above rel are zero.
  always_comb begin
    logic [PROD_W-1:0]       lo;
    logic [PROD_W-1:0]       hi;
    logic signed [SUM_W-1:0] acc;
    lanes_packed = '0;
    for (int g = 0; g < LANES; g++) begin
      lo  = PROD_W'(g) * PROD_W'(irrel_q);
      hi  = lo + PROD_W'(irrel_q);
      acc = '0;
      if (NUM_BITWIDTH'(g) < rel_q) begin
        for (int p = 0; p < NUM_PE; p++) begin
          if ((PROD_W'(p) >= lo) && (PROD_W'(p) < hi)) begin
            acc = acc + SUM_W'($signed(psum_out[p*DATA_BITWIDTH +: DATA_BITWIDTH]));
          end
        end
      end
`ifdef SU_ADDER_SAT_EN
      if (acc > C_SAT_MAX) begin
        acc = C_SAT_MAX;
      end else if (acc < C_SAT_MIN) begin
        acc = C_SAT_MIN;
      end
`endif
      lanes_packed[g*DATA_BITWIDTH +: DATA_BITWIDTH] = acc[DATA_BITWIDTH-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    irrel_d     = irrel_q;
    rel_d       = rel_q;
    rf_num_d    = rf_num_q;
    rf_addr_d   = rf_addr_q;
    rd_d        = 1'b0;
    wr_en_d     = rd_q;
    out_data_d  = rd_q ? lanes_packed : out_data_q;
    bram_addr_d = wr_en_q ? bram_addr_q + 1'b1 : bram_addr_q;
    cfg_err_d   = cfg_err_q;
    conv_pend_d = conv_pend_q | conv_finish;

    unique case (state_q)
      S_IDLE: begin
        // Pending rewind lands here, before any write of a run started this cycle.
        conv_pend_d = 1'b0;
        if (conv_finish || conv_pend_q) begin
          bram_addr_d = '0;
        end
        if (pe_psum_finish) begin
          irrel_d  = irrel_num;
          rel_d    = rel_num;
          rf_num_d = rf_num;
          if (cfg_legal) begin
            cfg_err_d = 1'b0;
            rf_addr_d = '0;
            state_d   = S_READ;
          end else begin
            cfg_err_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_READ: begin
        rd_d = 1'b1;
        if ({1'b0, rf_addr_q} == rf_num_q - 1'b1) begin
          state_d = S_DRAIN;
        end else begin
          rf_addr_d = rf_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (wr_en_q && !rd_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      irrel_q     <= '0;
      rel_q       <= '0;
      rf_num_q    <= '0;
      rf_addr_q   <= '0;
      rd_q        <= 1'b0;
      out_data_q  <= '0;
      wr_en_q     <= 1'b0;
      bram_addr_q <= '0;
      cfg_err_q   <= 1'b0;
      conv_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      irrel_q     <= irrel_d;
      rel_q       <= rel_d;
      rf_num_q    <= rf_num_d;
      rf_addr_q   <= rf_addr_d;
      rd_q        <= rd_d;
      out_data_q  <= out_data_d;
      wr_en_q     <= wr_en_d;
      bram_addr_q <= bram_addr_d;
      cfg_err_q   <= cfg_err_d;
      conv_pend_q <= conv_pend_d;
    end
  end

  assign psum_rf_addr   = rf_addr_q;
  assign out_data       = out_data_q;
  assign psum_write_en  = wr_en_q;
  assign psum_BRAM_addr = bram_addr_q;
  assign su_add_finish  = (state_q == S_DONE);
  assign cfg_err        = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_su_adder_param_irrel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_su_adder_param_irrel: scoreboard bench for su_adder_param_irrel.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_su_adder_param_irrel;

  localparam int DW  = 16;
  localparam int NPE = 256;
  localparam int GW  = 512;

  localparam int M_ONE  = 0;
  localparam int M_IDX  = 1;
  localparam int M_MAX  = 2;
  localparam int M_MIN  = 3;
  localparam int M_ADDR = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [DW*NPE-1:0] psum_out = '0;
  logic            pe_psum_finish = 1'b0;
  logic            conv_finish = 1'b0;
  logic [8:0]      irrel_num = '0;
  logic [8:0]      rel_num = '0;
  logic [2:0]      rf_num = '0;
  logic [1:0]      psum_rf_addr;
  logic [GW-1:0]   out_data;
  logic            psum_write_en;
  logic [9:0]      psum_BRAM_addr;
  logic            su_add_finish;
  logic            cfg_err;

  su_adder_param_irrel dut (
    .clk            (clk),
    .reset          (reset),
    .psum_out       (psum_out),
    .pe_psum_finish (pe_psum_finish),
    .conv_finish    (conv_finish),
    .irrel_num      (irrel_num),
    .rel_num        (rel_num),
    .rf_num         (rf_num),
    .psum_rf_addr   (psum_rf_addr),
    .out_data       (out_data),
    .psum_write_en  (psum_write_en),
    .psum_BRAM_addr (psum_BRAM_addr),
    .su_add_finish  (su_add_finish),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  int mode = M_ONE;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  bit wrote = 1'b0;

  typedef struct {
    logic [9:0]    addr;
    logic [GW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [DW-1:0] psum_val(int m, int p, int a);
    case (m)
      M_IDX:   psum_val = DW'(p);
      M_MAX:   psum_val = 16'h7FFF;
      M_MIN:   psum_val = 16'h8000;
      M_ADDR:  psum_val = DW'(a + 1);
      default: psum_val = 16'h0001;
    endcase
  endfunction

  // PE array model: RF read data appears one cycle after the address.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int p = 0; p < NPE; p++) begin
      psum_out[p*DW +: DW] <= psum_val(mode, p, int'(psum_rf_addr));
    end
  end

  task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [GW-1:0] word(input int rel, input int v);
    logic [GW-1:0] w;
    w = '0;
    for (int g = 0; g < rel; g++) w[g*DW +: DW] = DW'(v);
    return w;
  endfunction

  task automatic push_exp(input int addr, input logic [GW-1:0] data);
    exp_t e;
    e.addr = 10'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every write is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (psum_write_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 512'(psum_BRAM_addr), 512'h0);
        check("unexpected_write_en", 512'(psum_write_en), 512'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", 512'(psum_BRAM_addr), 512'(e.addr));
        check("wr_data", out_data, e.data);
      end
      last_wr_cyc = cyc;
      wrote = 1'b1;
    end
    if (su_add_finish && wrote) begin
      check("finish_after_last_write", 512'(cyc - last_wr_cyc), 512'd1);
      wrote = 1'b0;
    end
  end

  task automatic do_run(input int irr, input int rel, input int rfn,
                        input bit cf_start, input bit cf_mid, input bit exp_err);
    bit got;
    @(posedge clk); #1;
    irrel_num = 9'(irr);
    rel_num = 9'(rel);
    rf_num = 3'(rfn);
    pe_psum_finish = 1'b1;
    conv_finish = cf_start;
    @(posedge clk); #1;
    pe_psum_finish = 1'b0;
    conv_finish = 1'b0;
    irrel_num = 9'd7;
    rel_num = 9'd7;
    if (cf_mid) begin
      conv_finish = 1'b1;
      @(posedge clk); #1;
      conv_finish = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (su_add_finish) got = 1'b1;
    end
    check("finish_seen", 512'(got), 512'd1);
    check("cfg_err", 512'(cfg_err), 512'(exp_err));
    @(negedge clk);
    check("finish_one_cycle", 512'(su_add_finish), 512'd0);
  endtask

  initial begin
    logic [GW-1:0] w;
    bit seen;
    bit fin_seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_data", out_data, '0);
    check("rst_wr_en", 512'(psum_write_en), 512'd0);
    check("rst_bram_addr", 512'(psum_BRAM_addr), 512'd0);
    check("rst_finish", 512'(su_add_finish), 512'd0);
    check("rst_cfg_err", 512'(cfg_err), 512'd0);
    check("rst_rf_addr", 512'(psum_rf_addr), 512'd0);
    #1 reset = 1'b1;

    // all ones, 3 groups of 4
    mode = M_ONE;
    for (int a = 0; a < 4; a++) push_exp(a, word(3, 4));
    do_run(4, 3, 4, 1'b0, 1'b0, 1'b0);

    // address-dependent psums check RF address order; rewind requested mid-run
    mode = M_ADDR;
    for (int a = 0; a < 4; a++) push_exp(4 + a, word(3, 4 * (a + 1)));
    do_run(4, 3, 4, 1'b0, 1'b1, 1'b0);

    // PE index psums: lane g = 256g+120
    mode = M_IDX;
    w = '0;
    for (int g = 0; g < 16; g++) w[g*DW +: DW] = DW'(256 * g + 120);
    push_exp(0, w);
    do_run(16, 16, 1, 1'b0, 1'b0, 1'b0);

    // illegal configurations
    do_run(0, 3, 4, 1'b0, 1'b0, 1'b1);
    do_run(1, 33, 4, 1'b0, 1'b0, 1'b1);
    do_run(16, 17, 4, 1'b0, 1'b0, 1'b1);

    // positive and negative overflow; legal start clears cfg_err
    mode = M_MAX;
`ifdef SU_ADDER_SAT_EN
    push_exp(1, word(1, 16'h7FFF));
`else
    push_exp(1, word(1, 16'hFFFE));
`endif
    do_run(2, 1, 1, 1'b0, 1'b0, 1'b0);
    mode = M_MIN;
`ifdef SU_ADDER_SAT_EN
    push_exp(2, word(1, 16'h8000));
`else
    push_exp(2, word(1, 16'h0000));
`endif
    do_run(2, 1, 1, 1'b0, 1'b0, 1'b0);

    // walk the BRAM address up to 1022; first run rewinds with a simultaneous conv_finish
    mode = M_ONE;
    for (int r = 0; r < 255; r++) begin
      for (int a = 0; a < 4; a++) push_exp(4 * r + a, word(1, 1));
      do_run(1, 1, 4, r == 0, 1'b0, 1'b0);
    end
    push_exp(1020, word(1, 1));
    push_exp(1021, word(1, 1));
    do_run(1, 1, 2, 1'b0, 1'b0, 1'b0);
    push_exp(1022, word(2, 2));
    push_exp(1023, word(2, 2));
    push_exp(0, word(2, 2));
    push_exp(1, word(2, 2));
    do_run(2, 2, 4, 1'b0, 1'b0, 1'b0);

    // reset during READ after the first write
    push_exp(2, word(1, 1));
    @(posedge clk); #1;
    irrel_num = 9'd1;
    rel_num = 9'd1;
    rf_num = 3'd4;
    pe_psum_finish = 1'b1;
    @(posedge clk); #1;
    pe_psum_finish = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (psum_write_en) seen = 1'b1;
    end
    check("midrst_first_write_seen", 512'(seen), 512'd1);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_out_data", out_data, '0);
    check("midrst_wr_en", 512'(psum_write_en), 512'd0);
    check("midrst_bram_addr", 512'(psum_BRAM_addr), 512'd0);
    check("midrst_rf_addr", 512'(psum_rf_addr), 512'd0);
    check("midrst_finish", 512'(su_add_finish), 512'd0);
    #1 reset = 1'b1;
    fin_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (su_add_finish) fin_seen = 1'b1;
    end
    check("midrst_no_finish", 512'(fin_seen), 512'd0);

    push_exp(0, word(1, 1));
    do_run(1, 1, 1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 512'(exp_q.size()), 512'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/su_adder_param_irrel.md
Name: su_adder_param_irrel

Overview:
- Parametrised spatial-unrolling (SU) psum adder for the PE array.
- Reads every PE psum register-file (RF) entry in turn. Reduces groups of `irrel_num` adjacent PE psums, one group per output lane; `rel_num` groups per RF entry.
- Packs the group sums into one GBF-width word per RF entry and writes it to the psum BRAM.
- Successor to the fixed-config SU adder: runtime group sizes, RF entry count, configuration error detection, BRAM address control across convolutions, optional saturation.

Parameters:
- ROW, 16, PE array rows
- COL, 16, PE array columns
- DATA_BITWIDTH, 16, width of each psum and each output lane (signed two's complement)
- GBF_DATA_BITWIDTH, 512, BRAM word width; LANES = GBF_DATA_BITWIDTH/DATA_BITWIDTH (32)
- PSUM_RF_ADDR_BITWIDTH, 2, PE psum RF address width
- NUM_BITWIDTH, 9, width of `irrel_num`/`rel_num` (must hold ROW*COL)
- BRAM_ADDR_BITWIDTH, 10, psum BRAM address width

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- psum_out  in  DATA_BITWIDTH*ROW*COL  PE psums; PE p (p=r*COL+c) at [p*DATA_BITWIDTH +: DATA_BITWIDTH]; valid 1 cycle after psum_rf_addr
- pe_psum_finish  in  1  start request; sampled in IDLE
- conv_finish  in  1  end of convolution; rewinds psum_BRAM_addr
- irrel_num  in  NUM_BITWIDTH  PEs summed per group
- rel_num  in  NUM_BITWIDTH  groups per RF entry
- rf_num  in  PSUM_RF_ADDR_BITWIDTH+1  RF entries to process (1..2^PSUM_RF_ADDR_BITWIDTH)
- psum_rf_addr  out  PSUM_RF_ADDR_BITWIDTH  RF read address
- out_data  out  GBF_DATA_BITWIDTH  packed sums; lane g at [g*DATA_BITWIDTH +: DATA_BITWIDTH]
- psum_write_en  out  1  BRAM write strobe
- psum_BRAM_addr  out  BRAM_ADDR_BITWIDTH  BRAM write address
- su_add_finish  out  1  one-cycle done pulse
- cfg_err  out  1  sticky configuration error

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE. psum_rf_addr=0, out_data=0, psum_write_en=0, psum_BRAM_addr=0, su_add_finish=0, cfg_err=0. Reset mid-operation aborts with no further writes.
- Configuration (irrel_num, rel_num, rf_num) is latched on the cycle the block leaves IDLE; later changes are ignored until the next start.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On pe_psum_finish==1, check the latched configuration.
  - Legal (irrel_num>=1, rel_num>=1, rel_num<=LANES, irrel_num*rel_num<=ROW*COL, rf_num>=1): go to READ with psum_rf_addr=0.
  - Illegal: set cfg_err and go to DONE; no writes occur.
- READ: issue psum_rf_addr = 0..rf_num-1, one per cycle. After the last address, go to DRAIN.
- Pipeline:
  - Cycle t: address issued.
  - Cycle t+1: psum_out valid; lane sums are registered at the end of this cycle.
  - Cycle t+2: psum_write_en=1 with out_data. Address-to-write latency is 2 cycles.
- Lane sum: lane g (g<rel_num) = sum of PE psums p = g*irrel_num .. g*irrel_num+irrel_num-1, accumulated at full precision. Lanes g>=rel_num are 0. PEs beyond irrel_num*rel_num are ignored.
- Output width: the sum is truncated to the low DATA_BITWIDTH bits (wrap), unless SU_ADDER_SAT_EN is defined.
- BRAM address: psum_BRAM_addr increments by 1 on the cycle after each write and wraps 2^BRAM_ADDR_BITWIDTH-1 -> 0. It persists across runs.
- DRAIN: wait until the final write has issued, then go to DONE.
- DONE: su_add_finish=1 for exactly one cycle, then IDLE. A new start needs pe_psum_finish sampled again in IDLE; a level held high restarts immediately.
- conv_finish:
  - In IDLE: psum_BRAM_addr<=0.
  - Outside IDLE: remembered and applied on the IDLE entry cycle.
  - Simultaneous with pe_psum_finish in IDLE: the address rewind takes effect first, so the first write goes to address 0.
- cfg_err clears only on reset or on the next legal start.
- psum_write_en is 0 in every cycle except pipeline write cycles.

Optional Feature:
- Macro: SU_ADDER_SAT_EN.
- Defined: each lane sum saturates to the signed range [-2^(DATA_BITWIDTH-1), 2^(DATA_BITWIDTH-1)-1].
- Undefined: modulo-2^DATA_BITWIDTH wrap.
- Latency is identical in both builds.

Test Plan:
- All psums=1, irrel_num=4, rel_num=3, rf_num=4, pulse pe_psum_finish -> 4 writes at BRAM addr 0..3, lanes0-2=0x0004, other lanes 0; su_add_finish 1 cycle after the last write; rf_addr 0..3.
- PE p psum=p, irrel_num=16, rel_num=16, rf_num=1 -> lane g = sum of 16g..16g+15 = 256g+120; lanes 16-31 = 0.
- irrel_num=0, or rel_num=33, or irrel_num=16 with rel_num=17 -> cfg_err=1, no psum_write_en, su_add_finish pulse; next legal run clears cfg_err.
- Second run without conv_finish -> writes continue at addr 4..7; conv_finish asserted during that run -> the following run writes from addr 0; start with psum_BRAM_addr=1022 and rf_num=4 -> addresses 1022, 1023, 0, 1.
- All psums=0x7FFF, irrel_num=2, rel_num=1 -> lane0=0xFFFE (wrap build) or 0x7FFF (SU_ADDER_SAT_EN); all psums=0x8000 -> 0x0000 or 0x8000.
- reset driven low in READ after the first write -> all outputs 0 the next cycle, no further writes, state IDLE.
